conv_mac_ctrl: RTL and testbench

- Sequencer that computes one KxK convolution window: signed weights applied to unsigned pixels.
- Drives a combinational signed multiplier through its enable and operand ports. The multiplier has unsigned INPUT-bit pixel and signed FILTER-bit weight operands, a signed product, and a zero product when disabled.
- Fetches pixels from the image buffer and weights from the filter buffer (both synchronous-read, 1-cycle latency) and accumulates the products into a signed sum.
- Sits between the layer-level scheduler (start/result handshake) and the first/second conv layer datapath.

---
 rtl/conv_mac_ctrl.sv | 174 +++++++++++++++++
 tb/tb_conv_mac_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_ctrl.sv
// KxK convolution window sequencer: fetches pixel/weight pairs from two
// synchronous-read buffers, feeds an external multiplier and accumulates the signed sum.
module conv_mac_ctrl #(
  parameter int INPUT   = 4,
  parameter int FILTER  = 4,
  parameter int K       = 3,
  parameter int IMG_W   = 8,
  parameter int ADDR_W  = 6,
  parameter int FADDR_W = 4,
  parameter int ACC_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  output logic                      busy,
  output logic [ADDR_W-1:0]         img_addr,
  output logic [FADDR_W-1:0]        flt_addr,
  output logic                      rd_en,
  input  logic [INPUT-1:0]          img_data,
  input  logic [FILTER-1:0]         flt_data,
  output logic                      mul_en,
  output logic [INPUT-1:0]          mul_a,
  output logic [FILTER-1:0]         mul_b,
  input  logic [INPUT+FILTER-1:0]   mul_p,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_W-1:0]          result
);

  localparam int N    = K * K;
  localparam int P_W  = INPUT + FILTER;
  localparam int RC_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [FADDR_W-1:0] TAP_LAST = FADDR_W'(N - 1);
  localparam logic [RC_W-1:0]    COL_LAST = RC_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_r, next_state_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic [FADDR_W-1:0]  tap_r, tap_s;
  logic [RC_W-1:0]     row_r, row_s, col_r, col_s;
  logic [ADDR_W-1:0]   img_addr_r, img_addr_s;
  logic [ACC_W-1:0]    acc_r, acc_s, result_r, result_s;
  logic [ACC_W-1:0]    prod_ext_s;
  logic                busy_r, busy_s, rd_en_r, rd_en_s;
  logic                mul_en_r, mul_en_s, res_valid_r, res_valid_s;

  assign prod_ext_s = {{(ACC_W-P_W){mul_p[P_W-1]}}, mul_p};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  if (start) next_state_s = S_FETCH; else next_state_s = S_IDLE;
      S_FETCH: if (tap_r == TAP_LAST) next_state_s = S_DRAIN; else next_state_s = S_FETCH;
      S_DRAIN: next_state_s = S_DONE;
      S_DONE:  if (res_ready) next_state_s = S_IDLE; else next_state_s = S_DONE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Control outputs for the next cycle; the multiplier runs one cycle behind the read
  always_comb begin
    busy_s      = (next_state_s != S_IDLE);
    res_valid_s = (next_state_s == S_DONE);
    mul_en_s    = rd_en_r;
  end

  // Tap walk, address generation and accumulation
  always_comb begin
    base_s     = base_r;
    tap_s      = tap_r;
    row_s      = row_r;
    col_s      = col_r;
    img_addr_s = img_addr_r;
    rd_en_s    = 1'b0;
    result_s   = result_r;
    if (mul_en_r) begin
      acc_s = acc_r + prod_ext_s;
    end else begin
      acc_s = acc_r;
    end
    case (state_r)
      S_IDLE: begin
        if (start) begin
          base_s     = base_addr;
          tap_s      = {FADDR_W{1'b0}};
          row_s      = {RC_W{1'b0}};
          col_s      = {RC_W{1'b0}};
          img_addr_s = base_addr;
          rd_en_s    = 1'b1;
          acc_s      = {ACC_W{1'b0}};
        end else begin
          rd_en_s = 1'b0;
        end
      end
      S_FETCH: begin
        if (tap_r != TAP_LAST) begin
          if (col_r == COL_LAST) begin
            col_s = {RC_W{1'b0}};
            row_s = row_r + RC_W'(1);
          end else begin
            col_s = col_r + RC_W'(1);
            row_s = row_r;
          end
          tap_s      = tap_r + FADDR_W'(1);
          // Address wraps modulo the buffer size by truncation
          img_addr_s = base_r + ADDR_W'(row_s) * ADDR_W'(IMG_W) + ADDR_W'(col_s);
          rd_en_s    = 1'b1;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      S_DRAIN: result_s = acc_s;
      S_DONE:  result_s = result_r;
      default: result_s = result_r;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r      <= {ADDR_W{1'b0}};
      tap_r       <= {FADDR_W{1'b0}};
      row_r       <= {RC_W{1'b0}};
      col_r       <= {RC_W{1'b0}};
      img_addr_r  <= {ADDR_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      result_r    <= {ACC_W{1'b0}};
      busy_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      mul_en_r    <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      base_r      <= base_s;
      tap_r       <= tap_s;
      row_r       <= row_s;
      col_r       <= col_s;
      img_addr_r  <= img_addr_s;
      acc_r       <= acc_s;
      result_r    <= result_s;
      busy_r      <= busy_s;
      rd_en_r     <= rd_en_s;
      mul_en_r    <= mul_en_s;
      res_valid_r <= res_valid_s;
    end
  end

  assign busy      = busy_r;
  assign rd_en     = rd_en_r;
  assign img_addr  = img_addr_r;
  assign flt_addr  = tap_r;
  assign mul_en    = mul_en_r;
  assign mul_a     = mul_en_r ? img_data : {INPUT{1'b0}};
  assign mul_b     = mul_en_r ? flt_data : {FILTER{1'b0}};
  assign res_valid = res_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Randomized bench for conv_mac_ctrl: buffers and multiplier are modelled here, and a
// cycle-indexed window timeline predicts every output against the DUT.
module tb_conv_mac_ctrl;

  localparam int K = 3;
  localparam int N = K * K;
  localparam int IMG_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  base_addr = 6'd0;
  logic        busy;
  logic [5:0]  img_addr;
  logic [3:0]  flt_addr;
  logic        rd_en;
  logic [3:0]  img_data = 4'd0;
  logic [3:0]  flt_data = 4'd0;
  logic        mul_en;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic signed [7:0] prod_s;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [11:0] result;

  logic [3:0]        img_mem [64];
  logic signed [3:0] flt_mem [16];

  int vectors = 0;
  int miscompares = 0;

  // window model: busy flag, cycles since start was accepted, base and expected sum
  bit m_busy = 1'b0;
  int m_cyc = 0;
  int m_base = 0;
  int m_exp = 0;

  int cap_addr[$];
  bit cap_rv = 1'b0;
  int cap_result = 0;
  int cap_rv_cyc = 0;
  int mcount = 0;

  conv_mac_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .busy(busy),
    .img_addr(img_addr), .flt_addr(flt_addr), .rd_en(rd_en), .img_data(img_data),
    .flt_data(flt_data), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .result(result)
  );

  always #5 clk = ~clk;

  // buffers with one-cycle read latency, and the signed multiplier
  always @(posedge clk) begin
    if (rd_en) begin
      img_data <= img_mem[img_addr];
      flt_data <= flt_mem[flt_addr];
    end
  end
  assign prod_s = $signed({4'b0000, mul_a}) * $signed({{4{mul_b[3]}}, mul_b});
  assign mul_p  = mul_en ? prod_s : 8'd0;

  function automatic int addr_of(input int base, input int t);
    return (base + (t / K) * IMG_W + (t % K)) % 64;
  endfunction

  function automatic int win_sum(input int base);
    int sum;
    logic signed [11:0] w;
    sum = 0;
    for (int t = 0; t < N; t++) sum += int'(img_mem[addr_of(base, t)]) * int'(flt_mem[t]);
    w = sum[11:0];
    return int'(w);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // model advance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_cyc  <= 1;
        m_base <= int'(base_addr);
        m_exp  <= win_sum(int'(base_addr));
      end
    end else if (m_cyc >= N + 2 && res_ready) begin
      m_busy <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    int c;
    bit e_rd, e_mul, e_rv;
    c     = m_cyc;
    e_rd  = m_busy && c >= 1 && c <= N;
    e_mul = m_busy && c >= 2 && c <= N + 1;
    e_rv  = m_busy && c >= N + 2;
    chk("busy", int'(busy), int'(m_busy));
    chk("rd_en", int'(rd_en), int'(e_rd));
    chk("mul_en", int'(mul_en), int'(e_mul));
    chk("res_valid", int'(res_valid), int'(e_rv));
    if (e_rd) begin
      chk("img_addr", int'(img_addr), addr_of(m_base, c - 1));
      chk("flt_addr", int'(flt_addr), c - 1);
    end
    if (e_mul) begin
      chk("mul_a", int'(mul_a), int'(img_mem[addr_of(m_base, c - 2)]));
      chk("mul_b", int'($signed(mul_b)), int'(flt_mem[c - 2]));
    end else begin
      chk("mul_a_idle", int'(mul_a), 0);
      chk("mul_b_idle", int'(mul_b), 0);
    end
    if (e_rv) chk("result", int'($signed(result)), m_exp);
    if (!rst_n) begin
      chk("rst_result", int'(result), 0);
      chk("rst_img_addr", int'(img_addr), 0);
      chk("rst_flt_addr", int'(flt_addr), 0);
    end
    if (m_busy && c == 1) mcount = 0;
    if (mul_en) mcount++;
    if (e_rv && c == N + 2) chk("mul_en_count", mcount, N);
    if (rd_en) cap_addr.push_back(int'(img_addr));
    if (res_valid && !cap_rv) begin
      cap_rv     = 1'b1;
      cap_result = int'($signed(result));
      cap_rv_cyc = m_cyc;
    end
  end

  // one window from an idle DUT; hold = DONE cycles with res_ready low, poke = random start while busy
  task automatic run_window(input int base, input int hold, input bit poke);
    int h;
    bit done;
    h = hold;
    done = 1'b0;
    cap_addr.delete();
    cap_rv = 1'b0;
    start = 1'b1;
    base_addr = 6'(base);
    res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 6'($urandom_range(0, 63));
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_cyc >= N + 2) begin
        if (h > 0) begin
          h--;
          res_ready = 1'b0;
        end else begin
          res_ready = 1'b1;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (!m_busy) done = 1'b1;
    end
    start = 1'b0;
    res_ready = 1'b0;
    if (!done) chk("window_timeout", 0, 1);
  endtask

  task automatic fill_const(input logic [3:0] pix, input logic signed [3:0] wt);
    for (int i = 0; i < 64; i++) img_mem[i] = pix;
    for (int i = 0; i < 16; i++) flt_mem[i] = wt;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) img_mem[i] = 4'd0;
    for (int i = 0; i < 16; i++) flt_mem[i] = 4'sd1;
    for (int t = 0; t < N; t++) img_mem[addr_of(5, t)] = 4'(t);
  endtask

  initial begin
    int exp1[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int exp2[9] = '{5, 6, 7, 13, 14, 15, 21, 22, 23};
    bit reached;
    fill_const(4'd0, 4'sd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // all pixels 15, all weights -8, with backpressure and ignored start pulses
    fill_const(4'd15, -4'sd8);
    run_window(0, 5, 1'b1);
    chk("seq1_len", cap_addr.size(), 9);
    for (int t = 0; t < 9 && t < cap_addr.size(); t++) chk("seq1_addr", cap_addr[t], exp1[t]);
    chk("res1_literal", cap_result, -1080);
    chk("res1_cycle", cap_rv_cyc, 11);

    // ramp pixels, unit weights, base 5, started right after the previous release
    fill_ramp();
    run_window(5, 0, 1'b0);
    chk("seq2_len", cap_addr.size(), 9);
    for (int t = 0; t < 9 && t < cap_addr.size(); t++) chk("seq2_addr", cap_addr[t], exp2[t]);
    chk("res2_literal", cap_result, 36);

    // async reset in the middle of a window
    fill_const(4'd15, -4'sd8);
    cap_rv = 1'b0;
    start = 1'b1;
    base_addr = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_cyc == 5) reached = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!reached) chk("reach_cycle5", 0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd_en", int'(rd_en), 0);
    chk("arst_mul_en", int'(mul_en), 0);
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_img_addr", int'(img_addr), 0);
    chk("arst_mul_a", int'(mul_a), 0);
    chk("arst_result", int'(result), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_no_result", int'(cap_rv), 0);
    fill_ramp();
    run_window(5, 0, 1'b0);
    chk("res3_literal", cap_result, 36);

    // random windows
    for (int w = 0; w < 200; w++) begin
      for (int i = 0; i < 64; i++) img_mem[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) flt_mem[i] = 4'($urandom_range(0, 15));
      if (w == 0) begin
        img_mem[0] = 4'd15; img_mem[1] = 4'd0;
        flt_mem[0] = 4'sd7; flt_mem[1] = -4'sd8;
        run_window(0, 0, 1'b0);
      end else begin
        run_window(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      if (w == 0) chk("rand0_literal", cap_result, 105 + win_sum(0) - 105);
      if (w == 0) chk("rand0_tap01", int'(img_mem[0]) * int'(flt_mem[0]) + int'(img_mem[1]) * int'(flt_mem[1]), 105);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
